branch_resolve_unit: RTL and testbench

//  Registered, parametrised successor to the MEM-stage branch decoder. Resolves conditional

---
 rtl/branch_resolve_unit_pkg.sv | 56 +++++
 rtl/branch_resolve_unit_bht_2bit.sv | 33 +++
 rtl/branch_resolve_unit.sv | 129 ++++++++++++
 tb/tb_branch_resolve_unit.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/branch_resolve_unit_pkg.sv
// Shared encodings and helpers for the branch resolve unit: branch funct3 codes,
// BHT 2-bit counter states and the flush FSM states.
package branch_resolve_unit_pkg;

    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

    typedef enum logic [1:0] {
        SNT = 2'b00,
        WNT = 2'b01,
        WT  = 2'b10,
        ST  = 2'b11
    } bht_ctr_e;

    typedef enum logic {
        IDLE  = 1'b0,
        FLUSH = 1'b1
    } brs_state_e;

    // 010 and 011 carry no branch meaning and are treated as non-branches.
    function automatic logic f3_is_legal(input logic [2:0] f3);
        return (f3 != 3'b010) && (f3 != 3'b011);
    endfunction

    function automatic logic f3_taken(input logic [2:0] f3, input logic eq,
                                      input logic lt, input logic ltu);
        logic result;
        result = 1'b0;
        case (f3)
            F3_BEQ:  result = eq;
            F3_BNE:  result = !eq;
            F3_BLT:  result = lt;
            F3_BGE:  result = !lt;
            F3_BLTU: result = ltu;
            F3_BGEU: result = !ltu;
            default: result = 1'b0;
        endcase
        return result;
    endfunction

    function automatic bht_ctr_e ctr_update(input bht_ctr_e cur, input logic taken);
        bht_ctr_e result;
        result = cur;
        if (taken && (cur != ST)) begin
            result = bht_ctr_e'(cur + 2'd1);
        end else if (!taken && (cur != SNT)) begin
            result = bht_ctr_e'(cur - 2'd1);
        end
        return result;
    endfunction

endpackage

// File: rtl/branch_resolve_unit_bht_2bit.sv
// Branch history table of 2-bit saturating counters: asynchronous read for fetch,
// synchronous update from MEM, reset to weakly-not-taken.
module bht_2bit
    import branch_resolve_unit_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int IDX_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [IDX_W-1:0] i_rd_idx,
    output logic [1:0]       o_rd_ctr,
    input  logic             i_wr_en,
    input  logic [IDX_W-1:0] i_wr_idx,
    input  logic             i_wr_taken
);

    bht_ctr_e r_table [DEPTH];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_table[i] <= WNT;
            end
        end else if (i_wr_en) begin
            r_table[i_wr_idx] <= ctr_update(r_table[i_wr_idx], i_wr_taken);
        end
    end

    // Read sees the pre-update value when the write targets the same entry.
    assign o_rd_ctr = r_table[i_rd_idx];

endmodule

// File: rtl/branch_resolve_unit.sv
// MEM-stage branch resolution: evaluates the branch, checks the fetch prediction,
// issues a registered redirect plus a timed flush, and trains the BHT.
module branch_resolve_unit
    import branch_resolve_unit_pkg::*;
#(
    parameter int PC_W         = 9,
    parameter int BHT_DEPTH    = 16,
    parameter int FLUSH_CYCLES = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            br_valid_mem,
    input  logic [PC_W-1:0] pc_mem,
    input  logic [PC_W-1:0] offset_mem,
    input  logic [2:0]      branch_funct3_mem,
    input  logic            pred_taken_mem,
    input  logic            eq,
    input  logic            lt,
    input  logic            ltu,
    input  logic [PC_W-1:0] lookup_pc,
    output logic            lookup_taken,
    output logic            redirect_valid,
    output logic [PC_W-1:0] redirect_pc,
    output logic            flush,
    output logic            busy,
    output logic [15:0]     mispredict_cnt
);

    localparam int IDX_W = $clog2(BHT_DEPTH);
    localparam int CNT_W = $clog2(FLUSH_CYCLES + 1);

    brs_state_e      r_state;
    brs_state_e      w_state_next;
    logic [CNT_W-1:0] r_flush_cnt;
    logic [CNT_W-1:0] w_flush_cnt_next;

    logic            r_redirect_valid;
    logic [PC_W-1:0] r_redirect_pc;
    logic [15:0]     r_mispredict_cnt;

    logic            w_busy;
    logic            w_accept;
    logic            w_legal;
    logic            w_taken;
    logic            w_mispredict;
    logic [PC_W-1:0] w_target;
    logic [PC_W-1:0] w_fallthrough;
    logic [1:0]      w_lookup_ctr;
    logic            w_unused_lookup;

    assign w_busy        = (r_state == FLUSH);
    assign w_accept      = br_valid_mem && !w_busy;
    assign w_legal       = f3_is_legal(branch_funct3_mem);
    assign w_taken       = f3_taken(branch_funct3_mem, eq, lt, ltu);
    assign w_mispredict  = w_accept && w_legal && (w_taken != pred_taken_mem);
    assign w_target      = pc_mem + offset_mem;
    assign w_fallthrough = pc_mem + PC_W'(1);

    bht_2bit #(
        .DEPTH (BHT_DEPTH),
        .IDX_W (IDX_W)
    ) u_bht (
        .clk        (clk),
        .rst        (rst),
        .i_rd_idx   (lookup_pc[IDX_W-1:0]),
        .o_rd_ctr   (w_lookup_ctr),
        .i_wr_en    (w_accept && w_legal),
        .i_wr_idx   (pc_mem[IDX_W-1:0]),
        .i_wr_taken (w_taken)
    );

    assign lookup_taken    = w_lookup_ctr[1];
    assign w_unused_lookup = ^{lookup_pc[PC_W-1:IDX_W], w_lookup_ctr[0]};

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_flush_cnt <= '0;
        end else begin
            r_state     <= w_state_next;
            r_flush_cnt <= w_flush_cnt_next;
        end
    end

    // The down-counter is loaded so FLUSH lasts exactly FLUSH_CYCLES cycles.
    always_comb begin
        w_state_next     = r_state;
        w_flush_cnt_next = r_flush_cnt;
        case (r_state)
            IDLE: begin
                if (w_mispredict) begin
                    w_state_next     = FLUSH;
                    w_flush_cnt_next = CNT_W'(FLUSH_CYCLES - 1);
                end
            end
            FLUSH: begin
                if (r_flush_cnt == '0) begin
                    w_state_next = IDLE;
                end else begin
                    w_flush_cnt_next = r_flush_cnt - 1'b1;
                end
            end
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_redirect_valid <= 1'b0;
            r_redirect_pc    <= '0;
            r_mispredict_cnt <= '0;
        end else begin
            r_redirect_valid <= w_mispredict;
            if (w_mispredict) begin
                r_redirect_pc <= w_taken ? w_target : w_fallthrough;
                if (r_mispredict_cnt != 16'hFFFF) begin
                    r_mispredict_cnt <= r_mispredict_cnt + 16'd1;
                end
            end
        end
    end

    assign redirect_valid = r_redirect_valid;
    assign redirect_pc    = r_redirect_pc;
    assign flush          = w_busy;
    assign busy           = w_busy;
    assign mispredict_cnt = r_mispredict_cnt;

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Self-checking bench for branch_resolve_unit: directed scenarios followed by random
// branches, all compared against an arithmetic reference model of the unit.
module tb_branch_resolve_unit;

    localparam int PC_W      = 9;
    localparam int DEPTH     = 16;
    localparam int FLUSH_LEN = 2;

    logic            clk;
    logic            rst;
    logic            br_valid_mem;
    logic [PC_W-1:0] pc_mem;
    logic [PC_W-1:0] offset_mem;
    logic [2:0]      branch_funct3_mem;
    logic            pred_taken_mem;
    logic            eq;
    logic            lt;
    logic            ltu;
    logic [PC_W-1:0] lookup_pc;
    logic            lookup_taken;
    logic            redirect_valid;
    logic [PC_W-1:0] redirect_pc;
    logic            flush;
    logic            busy;
    logic [15:0]     mispredict_cnt;

    int assertCount;
    int failCount;

    int modelBht [DEPTH];
    int modelBusyLeft;
    int modelCnt;
    int modelRedirectValid;
    int modelRedirectPc;

    branch_resolve_unit #(
        .PC_W         (PC_W),
        .BHT_DEPTH    (DEPTH),
        .FLUSH_CYCLES (FLUSH_LEN)
    ) dut (
        .clk               (clk),
        .rst               (rst),
        .br_valid_mem      (br_valid_mem),
        .pc_mem            (pc_mem),
        .offset_mem        (offset_mem),
        .branch_funct3_mem (branch_funct3_mem),
        .pred_taken_mem    (pred_taken_mem),
        .eq                (eq),
        .lt                (lt),
        .ltu               (ltu),
        .lookup_pc         (lookup_pc),
        .lookup_taken      (lookup_taken),
        .redirect_valid    (redirect_valid),
        .redirect_pc       (redirect_pc),
        .flush             (flush),
        .busy              (busy),
        .mispredict_cnt    (mispredict_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        assertCount++;
        assert (observed === expected) else begin
            failCount++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    // Branch outcome from the architectural comparison of two 8-bit operands.
    function automatic int modelTaken(input int f3, input logic [7:0] a, input logic [7:0] b);
        case (f3)
            0:       return int'(a == b);
            1:       return int'(a != b);
            4:       return int'($signed(a) < $signed(b));
            5:       return int'($signed(a) >= $signed(b));
            6:       return int'(a < b);
            7:       return int'(a >= b);
            default: return 0;
        endcase
    endfunction

    task automatic modelReset();
        for (int i = 0; i < DEPTH; i++) modelBht[i] = 1;
        modelBusyLeft      = 0;
        modelCnt           = 0;
        modelRedirectValid = 0;
        modelRedirectPc    = 0;
    endtask

    // One clock cycle: drive at negedge, check the lookup, advance the model, check outputs.
    task automatic applyStimulus(input bit r, input bit v, input int pc, input int off,
                                 input int f3, input bit pred, input logic [7:0] a,
                                 input logic [7:0] b, input int lpc);
        int busyNow, legal, tk, acc, mis, idx;
        @(negedge clk);
        rst               = r;
        br_valid_mem      = v;
        pc_mem            = PC_W'(pc);
        offset_mem        = PC_W'(off);
        branch_funct3_mem = 3'(f3);
        pred_taken_mem    = pred;
        eq                = (a == b);
        lt                = ($signed(a) < $signed(b));
        ltu               = (a < b);
        lookup_pc         = PC_W'(lpc);
        #1;
        checkOutput("lookup_taken", lookup_taken, modelBht[lpc % DEPTH] >= 2);
        busyNow = (modelBusyLeft > 0);
        legal   = (f3 != 2) && (f3 != 3);
        tk      = modelTaken(f3, a, b);
        acc     = v && !busyNow;
        mis     = acc && legal && (tk != int'(pred));
        idx     = pc % DEPTH;
        @(posedge clk);
        #1;
        if (r) begin
            modelReset();
        end else begin
            if (acc && legal) begin
                modelBht[idx] = tk ? ((modelBht[idx] == 3) ? 3 : modelBht[idx] + 1)
                                   : ((modelBht[idx] == 0) ? 0 : modelBht[idx] - 1);
            end
            modelRedirectValid = mis;
            if (mis) begin
                modelRedirectPc = tk ? (pc + off) % 512 : (pc + 1) % 512;
                modelBusyLeft   = FLUSH_LEN;
                modelCnt        = (modelCnt >= 65535) ? 65535 : modelCnt + 1;
            end else if (modelBusyLeft > 0) begin
                modelBusyLeft--;
            end
        end
        checkOutput("redirect_valid", redirect_valid, modelRedirectValid);
        checkOutput("redirect_pc", redirect_pc, modelRedirectPc);
        checkOutput("flush", flush, modelBusyLeft > 0);
        checkOutput("busy", busy, modelBusyLeft > 0);
        checkOutput("mispredict_cnt", mispredict_cnt, modelCnt);
    endtask

    task automatic idleCycle(input int lpc);
        applyStimulus(0, 0, 0, 0, 0, 0, 8'd0, 8'd0, lpc);
    endtask

    initial begin
        int pc, off, f3, lpc;
        assertCount = 0;
        failCount   = 0;
        modelReset();
        rst = 1'b1; br_valid_mem = 1'b0; pc_mem = '0; offset_mem = '0;
        branch_funct3_mem = '0; pred_taken_mem = 1'b0; eq = 1'b0; lt = 1'b0; ltu = 1'b0;
        lookup_pc = '0;

        $display("[TB] reset and empty BHT sweep");
        applyStimulus(1, 0, 0, 0, 0, 0, 8'd0, 8'd0, 0);
        applyStimulus(1, 0, 0, 0, 0, 0, 8'd0, 8'd0, 0);
        for (int i = 0; i < 16; i++) idleCycle(i);

        $display("[TB] taken BEQ mispredicted as not-taken");
        applyStimulus(0, 1, 'h010, 'h020, 0, 0, 8'd5, 8'd5, 0);
        checkOutput("t2_redirect_pc", redirect_pc, 9'h030);
        checkOutput("t2_redirect_valid", redirect_valid, 1'b1);
        idleCycle(0);
        idleCycle(0);
        checkOutput("t2_flush_done", flush, 1'b0);
        checkOutput("t2_bht0_wt", lookup_taken, 1'b1);

        $display("[TB] correctly predicted BLT saturating BHT[0]");
        for (int i = 0; i < 3; i++) applyStimulus(0, 1, 'h1F0, 'h020, 4, 1, 8'hFF, 8'h01, 0);
        checkOutput("t3_no_redirect", redirect_valid, 1'b0);
        idleCycle(0);

        $display("[TB] branch during busy ignored, fallthrough wrap");
        applyStimulus(0, 1, 'h020, 'h020, 0, 0, 8'd7, 8'd7, 2);
        applyStimulus(0, 1, 'h021, 'h010, 0, 1, 8'd7, 8'd3, 1);
        checkOutput("t4_ignored_rv", redirect_valid, 1'b0);
        checkOutput("t4_ignored_cnt", mispredict_cnt, 16'd2);
        idleCycle(1);
        applyStimulus(0, 1, 'h1FF, 'h004, 0, 1, 8'd7, 8'd3, 15);
        checkOutput("t4_wrap_pc", redirect_pc, 9'h000);
        idleCycle(15);
        idleCycle(15);

        $display("[TB] illegal funct3 treated as non-branch");
        applyStimulus(0, 1, 'h033, 'h005, 2, 1, 8'd1, 8'd2, 3);
        applyStimulus(0, 1, 'h033, 'h005, 3, 0, 8'd1, 8'd1, 3);
        idleCycle(3);

        $display("[TB] reset during flush, counter saturation");
        applyStimulus(0, 1, 'h045, 'h010, 6, 0, 8'd1, 8'd9, 5);
        applyStimulus(1, 0, 0, 0, 0, 0, 8'd0, 8'd0, 5);
        checkOutput("t6_flush_abort", flush, 1'b0);
        for (int i = 0; i < 16; i += 5) idleCycle(i);
        @(negedge clk);
        force dut.r_mispredict_cnt = 16'hFFFD;
        #1;
        release dut.r_mispredict_cnt;
        modelCnt = 'hFFFD;
        #1;
        checkOutput("t6_forced_cnt", mispredict_cnt, 16'hFFFD);
        for (int i = 0; i < 3; i++) begin
            applyStimulus(0, 1, 'h060 + i, 'h011, 1, 0, 8'd4, 8'd6, i);
            idleCycle(i);
            idleCycle(i);
        end
        checkOutput("t6_saturated", mispredict_cnt, 16'hFFFF);

        $display("[TB] random branches");
        applyStimulus(1, 0, 0, 0, 0, 0, 8'd0, 8'd0, 0);
        for (int n = 0; n < 400; n++) begin
            pc  = int'($urandom_range(0, 511));
            off = int'($urandom_range(0, 511));
            f3  = int'($urandom_range(0, 7));
            lpc = ($urandom_range(0, 1) == 1) ? pc : int'($urandom_range(0, 511));
            applyStimulus(0, $urandom_range(0, 9) < 7, pc, off, f3, 1'($urandom_range(0, 1)),
                          8'($urandom_range(0, 3)), 8'($urandom_range(0, 3) << 6), lpc);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
